// File: rtl/piso_shift_register.sv
// piso_shift_register: valid/ready loaded parallel-in serial-out shifter
module piso_shift_register #(
    parameter int n = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load_valid,
    input  logic [n-1:0]             din,
    output logic                     load_ready,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(n+1)-1:0]   bits_left
);
    localparam int W = $clog2(n+1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [n-1:0] shreg;
    logic load, step, last;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    // next state: leave SHIFT on the enabled edge that sends the final bit
    always_comb begin
        load = state == IDLE && en && load_valid;
        step = state == SHIFT && en;
        last = step && bits_left == W'(1);
        state_nx = load ? SHIFT : last ? IDLE : state;
    end
    // outputs decoded from state and the output end of the shifter
    always_comb begin
        load_ready = state == IDLE && !rst;
        busy = state == SHIFT;
        sout_valid = state == SHIFT && en;
        sout = state == SHIFT && (MSB_FIRST ? shreg[n-1] : shreg[0]);
    end
    // datapath: capture word, shift toward the output end, count down, pulse done
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shreg <= '0;
            bits_left <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                shreg <= din;
                bits_left <= W'(n);
            end else if (step) begin
                shreg <= MSB_FIRST ? shreg << 1 : shreg >> 1;
                bits_left <= bits_left - W'(1);
            end
        end
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: vector table, corner sequences and queue-model random run
module tb_piso_shift_register;
    logic clk = 0, rst = 1, en = 0, load_valid = 0;
    logic [7:0] din = 0;
    logic lr_m, so_m, sv_m, bz_m, dn_m, lr_l, so_l, sv_l, bz_l, dn_l;
    logic [3:0] bl_m, bl_l;
    int tests = 0, fails = 0;
    piso_shift_register #(.n(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .din(din),
        .load_ready(lr_m), .sout(so_m), .sout_valid(sv_m), .busy(bz_m), .done(dn_m), .bits_left(bl_m)
    );
    piso_shift_register #(.n(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .din(din),
        .load_ready(lr_l), .sout(so_l), .sout_valid(sv_l), .busy(bz_l), .done(dn_l), .bits_left(bl_l)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] d;
        logic [7:0] em;
        logic [7:0] el;
        int stall_at;
        bit busy_ld;
        bit chain;
    } vec_t;
    vec_t vt[6];
    bit qm[$], ql[$];
    bit dm, dl;
    task automatic check(input string nm, input logic [31:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic chk(input string nm, input logic em, el, v, b, r, d, input logic [3:0] bl);
        check({nm, " sout_m"}, so_m, em);
        check({nm, " sout_l"}, so_l, el);
        check({nm, " valid_m"}, sv_m, v);
        check({nm, " valid_l"}, sv_l, v);
        check({nm, " busy_m"}, bz_m, b);
        check({nm, " busy_l"}, bz_l, b);
        check({nm, " ready_m"}, lr_m, r);
        check({nm, " ready_l"}, lr_l, r);
        check({nm, " done_m"}, dn_m, d);
        check({nm, " done_l"}, dn_l, d);
        check({nm, " bits_m"}, bl_m, bl);
        check({nm, " bits_l"}, bl_l, bl);
    endtask
    task automatic run_word(input logic [7:0] d, em, el, input int stall_at, input bit busy_ld, input string nm);
        check({nm, " ready_before"}, lr_m & lr_l, 1);
        load_valid = 1;
        din = d;
        en = 1;
        @(negedge clk);
        load_valid = busy_ld;
        din = busy_ld ? 8'hFF : 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                en = 0;
                repeat (3) begin
                    #1 chk({nm, " stall"}, em[7-i], el[7-i], 0, 1, 0, 0, 4'(8 - i));
                    @(negedge clk);
                end
                en = 1;
            end
            #1 chk($sformatf("%s bit%0d", nm, i), em[7-i], el[7-i], 1, 1, 0, 0, 4'(8 - i));
            @(negedge clk);
        end
        load_valid = 0;
        #1 chk({nm, " done"}, 0, 0, 0, 0, 1, 1, 0);
    endtask
    task automatic cmp_model(input string nm, input bit q[$], input bit dn, input logic s, v, b, r, d, input logic [3:0] bl);
        check({nm, " busy"}, b, q.size() > 0);
        check({nm, " ready"}, r, q.size() == 0);
        check({nm, " valid"}, v, q.size() > 0 && en);
        check({nm, " sout"}, s, q.size() > 0 ? q[0] : 1'b0);
        check({nm, " bits"}, bl, q.size());
        check({nm, " done"}, d, dn);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        vt[0] = '{8'h2D, 8'h2D, 8'hB4, -1, 0, 0};
        vt[1] = '{8'hF0, 8'hF0, 8'h0F, 2, 0, 0};
        vt[2] = '{8'h81, 8'h81, 8'h81, -1, 1, 1};
        vt[3] = '{8'hFF, 8'hFF, 8'hFF, -1, 0, 0};
        vt[4] = '{8'h01, 8'h01, 8'h80, -1, 0, 0};
        vt[5] = '{8'hC3, 8'hC3, 8'hC3, -1, 0, 0};
        #1 chk("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        en = 1;
        #1 chk("release", 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            run_word(vt[k].d, vt[k].em, vt[k].el, vt[k].stall_at, vt[k].busy_ld, $sformatf("vec%0d", k));
            if (!vt[k].chain) begin
                @(negedge clk);
                #1 chk($sformatf("vec%0d after", k), 0, 0, 0, 0, 1, 0, 0);
            end
        end
        load_valid = 1;
        din = 8'hAA;
        @(negedge clk);
        load_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("aa bit%0d", i), din[7-i], din[i], 1, 1, 0, 0, 4'(8 - i));
            @(negedge clk);
        end
        #2 rst = 1;
        #1 chk("midrst", 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        #1 chk("midrst release", 0, 0, 0, 0, 1, 0, 0);
        repeat (10) begin
            @(negedge clk);
            #1 chk("no done after rst", 0, 0, 0, 0, 1, 0, 0);
        end
        run_word(8'h55, 8'h55, 8'hAA, -1, 0, "w55");
        @(negedge clk);
        #1 chk("w55 after", 0, 0, 0, 0, 1, 0, 0);
        dm = 0;
        dl = 0;
        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1;
                #1 rst = 0;
                qm.delete();
                ql.delete();
                dm = 0;
                dl = 0;
            end
            en = $urandom_range(0, 3) != 0;
            load_valid = $urandom_range(0, 1);
            din = 8'($urandom);
            #1;
            cmp_model("rnd_m", qm, dm, so_m, sv_m, bz_m, lr_m, dn_m, bl_m);
            cmp_model("rnd_l", ql, dl, so_l, sv_l, bz_l, lr_l, dn_l, bl_l);
            @(posedge clk);
            dm = qm.size() == 1 && en;
            dl = ql.size() == 1 && en;
            if (qm.size() > 0) begin
                if (en) qm.delete(0);
            end else if (en && load_valid)
                for (int i = 7; i >= 0; i--) qm.push_back(din[i]);
            if (ql.size() > 0) begin
                if (en) ql.delete(0);
            end else if (en && load_valid)
                for (int i = 0; i < 8; i++) ql.push_back(din[i]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
